// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: opcodes, IR field positions, sequencer
// state codes and the branch-constant sign extension helper.
package cpu_pkg;

    // Opcode field values, IR[31:27]
    localparam logic [4:0] OP_LD    = 5'b00000;
    localparam logic [4:0] OP_LDI   = 5'b00001;
    localparam logic [4:0] OP_ST    = 5'b00010;
    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_AND   = 5'b00101;
    localparam logic [4:0] OP_OR    = 5'b00110;
    localparam logic [4:0] OP_SHR   = 5'b00111;
    localparam logic [4:0] OP_SHL   = 5'b01000;
    localparam logic [4:0] OP_ROR   = 5'b01001;
    localparam logic [4:0] OP_ROL   = 5'b01010;
    localparam logic [4:0] OP_ADDI  = 5'b01011;
    localparam logic [4:0] OP_ANDI  = 5'b01100;
    localparam logic [4:0] OP_ORI   = 5'b01101;
    localparam logic [4:0] OP_MUL   = 5'b01110;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_NEG   = 5'b10000;
    localparam logic [4:0] OP_NOT   = 5'b10001;
    localparam logic [4:0] OP_BR    = 5'b10010;
    localparam logic [4:0] OP_JR    = 5'b10011;
    localparam logic [4:0] OP_JAL   = 5'b10100;
    localparam logic [4:0] OP_IN    = 5'b10101;
    localparam logic [4:0] OP_OUT   = 5'b10110;
    localparam logic [4:0] OP_MFHI  = 5'b10111;
    localparam logic [4:0] OP_MFLO  = 5'b11000;
    localparam logic [4:0] OP_NOP   = 5'b11001;
    localparam logic [4:0] OP_HALT  = 5'b11010;

    // IR field bit positions
    localparam int unsigned OP_HI = 31;
    localparam int unsigned OP_LO = 27;
    localparam int unsigned RA_HI = 26;
    localparam int unsigned RA_LO = 23;
    localparam int unsigned C2_HI = 22;
    localparam int unsigned C2_LO = 19;
    localparam int unsigned C_HI  = 18;
    localparam int unsigned C_LO  = 0;

    // Branch sequencer state codes
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T3   = 3'd1;
    localparam logic [2:0] S_T4   = 3'd2;
    localparam logic [2:0] S_T5   = 3'd3;
    localparam logic [2:0] S_T6   = 3'd4;

    // Sign-extend the 19-bit C field to a full word
    function automatic logic [31:0] sext_c(input logic [31:0] ir);
        return {{13{ir[C_HI]}}, ir[C_HI:C_LO]};
    endfunction

endpackage

// File: rtl/branch_seq_if.sv
// Decoder/datapath-facing signal bundle of the branch sequencer.
// master: decoder + datapath side; slave: the sequencer itself.
interface branch_seq_if;
    logic        start;
    logic [31:0] ir;
    logic        con;
    logic        busy;
    logic        done;
    logic        taken;
    logic        err;
    logic        gra;
    logic        rout;
    logic        con_in;
    logic        pc_out;
    logic        y_in;
    logic        c_out;
    logic [31:0] c_sext;
    logic        alu_add;
    logic        z_in;
    logic        zlow_out;
    logic        pc_in;

    modport master (
        output start, ir, con,
        input  busy, done, taken, err, gra, rout, con_in, pc_out, y_in,
               c_out, c_sext, alu_add, z_in, zlow_out, pc_in
    );

    modport slave (
        input  start, ir, con,
        output busy, done, taken, err, gra, rout, con_in, pc_out, y_in,
               c_out, c_sext, alu_add, z_in, zlow_out, pc_in
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // Count up on inc until all-ones is reached
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/branch_seq.sv
// Conditional-branch control sequencer (steps T3..T6 after fetch).
// Optional taken/not-taken statistics: define BRANCH_SEQ_STATS_EN.
module branch_seq
    import cpu_pkg::*;
#(
    parameter logic [4:0]  BR_OPCODE = OP_BR,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk,
    input  logic        clr,
    branch_seq_if.slave bus
`ifdef BRANCH_SEQ_STATS_EN
    ,
    output logic [CNT_W-1:0] n_taken,
    output logic [CNT_W-1:0] n_not_taken
`endif
);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic       is_br;
    logic       idle;
    logic       accept;
    logic       taken_q;
    logic       err_q;

    assign is_br  = (bus.ir[OP_HI:OP_LO] == BR_OPCODE);
    assign idle   = (state == S_IDLE);
    assign accept = idle && bus.start && is_br;

    // Next-state: fixed walk T3..T6 once a branch is accepted
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_T3;
            S_T3:    state_nx = S_T4;
            S_T4:    state_nx = S_T5;
            S_T5:    state_nx = S_T6;
            S_T6:    state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register; clr abandons any sequence in flight
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Branch decision: cleared on accept, captures CON at the end of T5
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            taken_q <= 1'b0;
        else if (accept)
            taken_q <= 1'b0;
        else if (state == S_T5)
            taken_q <= bus.con;
    end

    // Illegal-opcode flag: one-cycle pulse the cycle after the rejected start
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            err_q <= 1'b0;
        else
            err_q <= idle && bus.start && !is_br;
    end

    // Datapath strobes decoded from state; pc_in also qualified by taken
    always_comb begin
        bus.gra      = 1'b0;
        bus.rout     = 1'b0;
        bus.con_in   = 1'b0;
        bus.pc_out   = 1'b0;
        bus.y_in     = 1'b0;
        bus.c_out    = 1'b0;
        bus.alu_add  = 1'b0;
        bus.z_in     = 1'b0;
        bus.zlow_out = 1'b0;
        bus.pc_in    = 1'b0;
        bus.done     = 1'b0;
        case (state)
            S_T3: begin
                bus.gra    = 1'b1;
                bus.rout   = 1'b1;
                bus.con_in = 1'b1;
            end
            S_T4: begin
                bus.pc_out = 1'b1;
                bus.y_in   = 1'b1;
            end
            S_T5: begin
                bus.c_out   = 1'b1;
                bus.alu_add = 1'b1;
                bus.z_in    = 1'b1;
            end
            S_T6: begin
                bus.zlow_out = 1'b1;
                bus.done     = 1'b1;
                bus.pc_in    = taken_q;
            end
            default: ;
        endcase
    end

    assign bus.busy   = !idle;
    assign bus.taken  = taken_q;
    assign bus.err    = err_q;
    assign bus.c_sext = sext_c(bus.ir);

`ifdef BRANCH_SEQ_STATS_EN
    logic leave_t6;
    assign leave_t6 = (state == S_T6);

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk (clk),
        .clr (clr),
        .inc (leave_t6 && taken_q),
        .q   (n_taken)
    );

    sat_counter #(.CNT_W(CNT_W)) u_not_taken_cnt (
        .clk (clk),
        .clr (clr),
        .inc (leave_t6 && !taken_q),
        .q   (n_not_taken)
    );
`endif

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: vector table, corner sequences,
// randomized runs against a step-table reference model.
// Statistics checks are enabled with BRANCH_SEQ_STATS_EN.
module tb_branch_seq;
    import cpu_pkg::*;

    localparam int unsigned TB_CNT_W = 3;

    logic clk;
    logic clr;
    branch_seq_if bif ();

`ifdef BRANCH_SEQ_STATS_EN
    logic [TB_CNT_W-1:0] n_taken;
    logic [TB_CNT_W-1:0] n_not_taken;
`endif

    branch_seq #(.BR_OPCODE(5'b10010), .CNT_W(TB_CNT_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bif)
`ifdef BRANCH_SEQ_STATS_EN
        ,
        .n_taken     (n_taken),
        .n_not_taken (n_not_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mism     = 0;
    int m_taken  = 0;
    int m_nt     = 0;
    int pc_in_seen = 0;

    // Strobe order: gra rout con_in pc_out y_in c_out alu_add z_in zlow_out pc_in
    logic [9:0] exp_strb [4];

    typedef struct {
        logic [31:0] ir;
        logic [3:0]  con_seq;   // bit k = con during step k (T3..T6)
        logic [3:0]  restart;   // bit k = extra start pulse during step k
        logic        exp_taken;
        logic [31:0] exp_csext;
    } vec_t;

    vec_t vecs [6];

    always @(negedge clk) if (bif.pc_in) pc_in_seen++;

    function automatic logic [9:0] strobes();
        return {bif.gra, bif.rout, bif.con_in, bif.pc_out, bif.y_in,
                bif.c_out, bif.alu_add, bif.z_in, bif.zlow_out, bif.pc_in};
    endfunction

    function automatic logic [31:0] csext_model(input logic [31:0] ir);
        longint v;
        v = longint'(ir) % 524288;
        if (v >= 262144) v = v - 524288;
        return v[31:0];
    endfunction

    function automatic int sat(input int v);
        int mx;
        mx = (1 << TB_CNT_W) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bus_onehot_chk();
        compared++;
        assert ($onehot0({bif.rout, bif.pc_out, bif.c_out, bif.zlow_out}))
        else begin
            mism++;
            $display("FAIL bus_onehot: drivers=%b required at most one",
                     {bif.rout, bif.pc_out, bif.c_out, bif.zlow_out});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stats_chk();
`ifdef BRANCH_SEQ_STATS_EN
        chk("n_taken", 64'(n_taken), 64'(sat(m_taken)));
        chk("n_not_taken", 64'(n_not_taken), 64'(sat(m_nt)));
`endif
    endtask

    // Entered and left at posedge+1; start issued in the entry cycle
    task automatic run_branch(input logic [31:0] ir, input logic [3:0] cs, input logic [3:0] rs);
        logic [31:0] exp_c;
        logic        exp_t;
        exp_c = csext_model(ir);
        exp_t = cs[2];
        bif.ir    = ir;
        bif.start = 1'b1;
        bif.con   = 1'($urandom);
        @(negedge clk);
        chk("busy_in_start_cycle", 64'(bif.busy), 64'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            bif.con   = cs[k];
            bif.start = rs[k];
            @(negedge clk);
            chk($sformatf("strobes_T%0d", k + 3), 64'(strobes()),
                64'(exp_strb[k] | ((k == 3) ? 10'(exp_t) : 10'd0)));
            chk($sformatf("busy_T%0d", k + 3), 64'(bif.busy), 64'd1);
            chk($sformatf("done_T%0d", k + 3), 64'(bif.done), 64'(k == 3));
            chk($sformatf("err_T%0d", k + 3), 64'(bif.err), 64'd0);
            chk($sformatf("c_sext_T%0d", k + 3), 64'(bif.c_sext), 64'(exp_c));
            bus_onehot_chk();
            if (k == 3) chk("taken_T6", 64'(bif.taken), 64'(exp_t));
            step();
        end
        bif.start = 1'b0;
        if (exp_t) m_taken++; else m_nt++;
        chk("busy_after", 64'(bif.busy), 64'd0);
        chk("taken_held", 64'(bif.taken), 64'(exp_t));
        stats_chk();
    endtask

    task automatic run_illegal(input logic [31:0] ir);
        bif.ir    = ir;
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
        @(negedge clk);
        chk("err_pulse", 64'(bif.err), 64'd1);
        chk("err_busy", 64'(bif.busy), 64'd0);
        chk("err_strobes", 64'(strobes()), 64'd0);
        step();
        @(negedge clk);
        chk("err_cleared", 64'(bif.err), 64'd0);
        chk("err_still_idle", 64'(bif.busy), 64'd0);
        step();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        m_taken = 0;
        m_nt    = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_ir;
        logic [4:0]  r_op;
        int          seen;

        exp_strb[0] = 10'b1110000000;
        exp_strb[1] = 10'b0001100000;
        exp_strb[2] = 10'b0000011100;
        exp_strb[3] = 10'b0000000010;

        vecs[0] = '{32'h9000_0008, 4'b1110, 4'b0000, 1'b1, 32'h0000_0008};
        vecs[1] = '{32'h9000_0008, 4'b0000, 4'b0000, 1'b0, 32'h0000_0008};
        vecs[2] = '{32'h9007_FFFC, 4'b1011, 4'b0000, 1'b0, 32'hFFFF_FFFC};
        vecs[3] = '{32'h9780_0123, 4'b0100, 4'b0000, 1'b1, 32'h0000_0123};
        vecs[4] = '{32'h9004_0000, 4'b1111, 4'b0010, 1'b1, 32'hFFFC_0000};
        vecs[5] = '{32'h9000_0040, 4'b1010, 4'b1111, 1'b0, 32'h0000_0040};

        clr       = 1'b1;
        bif.start = 1'b0;
        bif.ir    = '0;
        bif.con   = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("reset_outputs", 64'({strobes(), bif.busy, bif.done, bif.taken, bif.err}), 64'd0);
        stats_chk();
        step();
        clr = 1'b0;

        // Vector table: hand-derived expected taken / c_sext
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("vec%0d_csext_model", i), 64'(csext_model(vecs[i].ir)), 64'(vecs[i].exp_csext));
            chk($sformatf("vec%0d_taken_rule", i), 64'(vecs[i].con_seq[2]), 64'(vecs[i].exp_taken));
            run_branch(vecs[i].ir, vecs[i].con_seq, vecs[i].restart);
            chk($sformatf("vec%0d_taken", i), 64'(bif.taken), 64'(vecs[i].exp_taken));
        end

        // Illegal opcodes, including one bit away from the branch opcode
        run_illegal(32'h0800_0000);
        run_illegal(32'h9800_0000);
        run_illegal(32'h1000_0008);

        // Asynchronous reset in T5 with con=1: sequence abandoned, no pc_in
        bif.ir    = 32'h9000_0010;
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
        bif.con   = 1'b1;
        step();
        step();
        seen = pc_in_seen;
        #2;
        clr = 1'b1;
        #1;
        chk("clr_async_outputs", 64'({strobes(), bif.busy, bif.done, bif.taken, bif.err}), 64'd0);
        m_taken = 0;
        m_nt    = 0;
        stats_chk();
        step();
        step();
        chk("clr_no_pc_in", 64'(pc_in_seen), 64'(seen));
        clr = 1'b0;
        step();
        chk("clr_idle_after", 64'(bif.busy), 64'd0);
        run_branch(32'h9000_0010, 4'b0100, 4'b0000);

`ifdef BRANCH_SEQ_STATS_EN
        // 3 taken + 2 not-taken from a fresh clear
        pulse_clr();
        run_branch(32'h9000_0001, 4'b0100, 4'b0000);
        run_branch(32'h9000_0002, 4'b0000, 4'b0000);
        run_branch(32'h9000_0003, 4'b1111, 4'b0010);
        run_branch(32'h9000_0004, 4'b1011, 4'b0000);
        run_branch(32'h9000_0005, 4'b0110, 4'b0000);
        chk("stats_n_taken_3", 64'(n_taken), 64'd3);
        chk("stats_n_not_taken_2", 64'(n_not_taken), 64'd2);
`endif

        // Randomized runs against the model; counters saturate along the way
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                r_op = 5'($urandom);
                if (r_op == OP_BR) r_op = OP_ADD;
                r_ir = {r_op, 27'($urandom)};
                run_illegal(r_ir);
            end else begin
                r_ir = {OP_BR, 27'($urandom)};
                run_branch(r_ir, 4'($urandom), 4'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule

// File: doc/branch_seq.md
Name: branch_seq

Overview:
- Control-side sequencer for conditional branch instructions.
- Drives the datapath strobes that load the CON flip-flop, compute PC+C through Y/ALU/Z, and conditionally load PC.
- Consumes the condition flag (`con`) that the CON flip-flop logic produces.
- Sits between the instruction decoder (which issues `start` after fetch step T2) and the datapath register/bus enables.

Parameters:
- BR_OPCODE, 5'b10010, value of IR[31:27] that identifies a branch instruction.
- CNT_W, 16, width of taken/not-taken counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse from decoder; the instruction in `ir` is to be executed.
- ir  in  32  current instruction register contents, stable from `start` through `done`.
- con  in  1  CON flip-flop output.
- busy  out  1  high while the sequence runs (T3..T6).
- done  out  1  one-cycle pulse in T6.
- taken  out  1  registered; value of `con` sampled in T5, held until next `start`.
- err  out  1  one-cycle pulse when `start` arrives with IR[31:27] != BR_OPCODE.
- gra  out  1  select Ra field (IR[26:23]) for register read.
- rout  out  1  register file drives bus.
- con_in  out  1  CON flip-flop capture enable.
- pc_out  out  1  PC drives bus.
- y_in  out  1  Y register load.
- c_out  out  1  sign-extended constant drives bus.
- c_sext  out  32  {{13{ir[18]}}, ir[18:0]}, combinational.
- alu_add  out  1  ALU operation select = ADD.
- z_in  out  1  Z register load.
- zlow_out  out  1  Zlow drives bus.
- pc_in  out  1  PC load.

Behaviour:
- Reset (`clr`=1, asynchronous): state=IDLE; all strobes, `busy`, `done`, `err` and `taken` are 0. This applies at any point, including mid-sequence; the sequence is abandoned and no `pc_in` is issued.
- States: IDLE, T3, T4, T5, T6. Strobes are Moore outputs decoded from state, except `pc_in`.
- IDLE: on `start` with IR[31:27]==BR_OPCODE, go to T3 on the next edge. On `start` with any other opcode, stay IDLE and pulse `err` for one cycle.
- T3: gra=1, rout=1, con_in=1. Next state T4.
- T4: pc_out=1, y_in=1. Next state T5.
- T5: c_out=1, alu_add=1, z_in=1. Register `taken` <= `con`; CON is valid here, two edges after con_in. Next state T6.
- T6: zlow_out=1, done=1, pc_in=`taken`. Next state IDLE.
- `busy`=1 in T3..T6. A `start` while busy is ignored: no `err` and no restart.
- Latency: `start` at cycle n gives T3 at n+1, `done` at n+4, PC updated at the edge ending n+4. The next `start` is accepted in cycle n+5.
- Exactly one bus driver is active per state (rout, pc_out, c_out, zlow_out mutually exclusive). The bench checks this with an assertion.
- Changes of `con` outside T5 have no effect on `pc_in`.

Optional Feature:
- Macro: BRANCH_SEQ_STATS_EN.
- With the macro: adds outputs `n_taken`[CNT_W] and `n_not_taken`[CNT_W]. One of them increments at the edge leaving T6, according to `taken`. Both saturate at all-ones. Both reset to 0 on `clr`.
- Without the macro: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg: state enum (IDLE, T3..T6), opcode constants (BR_OPCODE plus the other opcodes), IR field bit positions (OP, RA, C2, C).
- One natural sub-module, `sat_counter` (CNT_W, inc, clr, q), instantiated twice under BRANCH_SEQ_STATS_EN. Everything else stays in branch_seq.

Test Plan:
- Taken branch: ir=0x9000_0008 (op 10010, C=8), start pulse, con=1 from T4 -> strobes follow T3..T6 exactly; pc_in=1 and done=1 in T6; taken=1.
- Not taken: same ir, con=0 -> identical strobes except pc_in=0 in T6; taken=0.
- Negative offset: C field=0x7FFFC -> c_sext=0xFFFF_FFFC during T5.
- Illegal start: ir=0x0800_0000 with start -> err pulses 1 cycle, busy stays 0, no strobes.
- Reset mid-run: assert clr during T5 with con=1 -> all outputs 0 immediately (asynchronous), never pc_in; a start after release runs normally.
- Start while busy: second start in T4 -> ignored. With BRANCH_SEQ_STATS_EN, 3 taken + 2 not-taken runs give n_taken=3, n_not_taken=2.
